// File: rtl/nibble_serial_adder.sv
// Digit-serial adder: adds two width_out-bit operands one width_in-bit digit per clock,
// LSB digit first, under a start/busy/done handshake with operands captured at start.
module nibble_serial_adder #(
  parameter int unsigned width_in  = 4,
  parameter int unsigned width_out = 16
) (
  input  logic                 clk,
  input  logic                 rst_p,
  input  logic                 start,
  input  logic [width_out-1:0] addA,
  input  logic [width_out-1:0] addB,
  output logic [width_out-1:0] sum,
  output logic                 cout,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int unsigned NumDig = width_out / width_in;
  localparam int unsigned IdxW   = (NumDig > 1) ? $clog2(NumDig) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NumDig - 1);

  typedef enum logic [1:0] {StIdle, StAdd, StDone} state_e;

  state_e               state_q, state_d;
  logic [width_out-1:0] op_a_q, op_a_d;
  logic [width_out-1:0] op_b_q, op_b_d;
  logic [width_out-1:0] sum_q, sum_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic                 carry_q, carry_d;
  logic                 cout_q, cout_d;
  logic                 ovf_q, ovf_d;

  logic [width_in-1:0]  a_dig, b_dig;
  logic [width_in:0]    t;
  int unsigned          base;

  always_comb begin
    base  = int'(idx_q) * width_in;
    a_dig = op_a_q[base +: width_in];
    b_dig = op_b_q[base +: width_in];
    t     = {1'b0, a_dig} + {1'b0, b_dig} + (width_in + 1)'(carry_q);
  end

  always_comb begin
    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    sum_d   = sum_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          op_a_d  = addA;
          op_b_d  = addB;
          carry_d = 1'b0;
          idx_d   = '0;
          state_d = StAdd;
        end
      end
      StAdd: begin
        sum_d[base +: width_in] = t[width_in-1:0];
        carry_d = t[width_in];
        if (idx_q == LastIdx) begin
          // Top digit: carry leaves via cout only, never wraps into digit 0.
          cout_d  = t[width_in];
          ovf_d   = (op_a_q[width_out-1] == op_b_q[width_out-1]) &&
                    (t[width_in-1] != op_a_q[width_out-1]);
          idx_d   = '0;
          state_d = StDone;
        end else begin
          idx_d = idx_q + IdxW'(1);
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_p) begin
      state_q <= StIdle;
      op_a_q  <= '0;
      op_b_q  <= '0;
      sum_q   <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      sum_q   <= sum_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == StAdd) || (state_q == StDone);
  assign done = (state_q == StDone);

endmodule
